ram_ctrl: RTL and testbench

//   Command sequencer sitting directly upstream of the 8x8 synchronous RAM. It accepts

---
 rtl/ram_ctrl_pkg.sv | 17 +
 rtl/ram_ctrl.sv | 93 +++++++++
 tb/tb_ram_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/ram_ctrl_pkg.sv
// Shared widths and FSM state encodings for the RAM command sequencer.
// State encodings are plain localparams so legacy code can keep comparing raw values.
package ram_ctrl_pkg;

  localparam int unsigned ADDR_W_DEF = 3;
  localparam int unsigned DATA_W_DEF = 8;

  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE     = 3'd0;
  localparam logic [STATE_W-1:0] ST_WRITE    = 3'd1;
  localparam logic [STATE_W-1:0] ST_RD_ISSUE = 3'd2;
  localparam logic [STATE_W-1:0] ST_RD_CAPT  = 3'd3;
  localparam logic [STATE_W-1:0] ST_RESP     = 3'd4;
  localparam logic [STATE_W-1:0] ST_CLEAR    = 3'd5;

endpackage

// File: rtl/ram_ctrl.sv
// Single-outstanding command sequencer in front of a synchronous RAM (1-cycle read latency).
// Optional zero-fill engine enabled by defining RAM_CTRL_CLEAR_EN.
module ram_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              ram_write_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_write_data,
  input  logic [DATA_W-1:0] ram_read_data
`ifdef RAM_CTRL_CLEAR_EN
  ,
  input  logic              clear,
  output logic              clear_busy
`endif
);

  logic [STATE_W-1:0] state;
  logic               idle;
  logic               clear_start;
  logic               accept;

  assign idle = (state == ST_IDLE);

`ifdef RAM_CTRL_CLEAR_EN
  // Clear wins over a pending command, so ready is withheld in that cycle.
  assign clear_start = idle & clear;
  assign clear_busy  = (state == ST_CLEAR);
`else
  assign clear_start = 1'b0;
`endif

  assign cmd_ready    = idle & ~clear_start;
  assign accept       = cmd_valid & cmd_ready;
  assign ram_write_en = (state == ST_WRITE) | (state == ST_CLEAR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      ram_addr       <= '0;
      ram_write_data <= '0;
      rsp_valid      <= 1'b0;
      rsp_data       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (clear_start) begin
            state          <= ST_CLEAR;
            ram_addr       <= '0;
            ram_write_data <= '0;
          end else if (accept) begin
            ram_addr       <= cmd_addr;
            ram_write_data <= cmd_data;
            state          <= cmd_write ? ST_WRITE : ST_RD_ISSUE;
          end
        end
        ST_WRITE:    state <= ST_IDLE;
        ST_RD_ISSUE: state <= ST_RD_CAPT;
        ST_RD_CAPT: begin
          rsp_data  <= ram_read_data;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
`ifdef RAM_CTRL_CLEAR_EN
        ST_CLEAR: begin
          if (ram_addr == {ADDR_W{1'b1}}) state <= ST_IDLE;
          else ram_addr <= ram_addr + 1'b1;
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_ctrl.sv
// Directed bench for ram_ctrl with a behavioural 8x8 synchronous RAM alongside it.
// Define RAM_CTRL_CLEAR_EN to also exercise the zero-fill path.
module tb_ram_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [2:0] cmd_addr;
  logic [7:0] cmd_data;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_data;
  logic       ram_write_en;
  logic [2:0] ram_addr;
  logic [7:0] ram_write_data, ram_read_data;
`ifdef RAM_CTRL_CLEAR_EN
  logic       clear, clear_busy;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ram_ctrl #(.ADDR_W(3), .DATA_W(8)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .ram_write_en(ram_write_en), .ram_addr(ram_addr),
    .ram_write_data(ram_write_data), .ram_read_data(ram_read_data)
`ifdef RAM_CTRL_CLEAR_EN
    , .clear(clear), .clear_busy(clear_busy)
`endif
  );

  // Behavioural RAM: cleared by reset, registered read when write_en=0.
  logic [7:0] mem [8];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) mem[i] <= 8'h00;
      ram_read_data <= 8'h00;
    end else if (ram_write_en) begin
      mem[ram_addr] <= ram_write_data;
    end else begin
      ram_read_data <= mem[ram_addr];
    end
  end

  typedef struct {
    logic       wr;
    logic [2:0] addr;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge just after the accept edge.
  task automatic send(input logic wr, input logic [2:0] a, input logic [7:0] d);
    int n;
    n = 0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_data = d;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) check("cmd_ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic read_expect(input string name, input logic [2:0] a, input logic [7:0] exp);
    int n;
    send(1'b0, a, 8'h00);
    n = 0;
    while (!rsp_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check(name, {24'd0, rsp_data}, {24'd0, exp});
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_data = '0;
    rsp_ready = 1'b0;
`ifdef RAM_CTRL_CLEAR_EN
    clear = 1'b0;
`endif
    for (int i = 0; i < 8; i++) begin
      vecs[i]     = '{wr: 1'b1, addr: 3'(i), data: 8'(8'h10 + i), exp: 8'h00};
      vecs[8 + i] = '{wr: 1'b0, addr: 3'(i), data: 8'h00, exp: 8'(8'h10 + i)};
    end
    vecs[16] = '{wr: 1'b1, addr: 3'd0, data: 8'h00, exp: 8'h00};
    vecs[17] = '{wr: 1'b1, addr: 3'd7, data: 8'hFF, exp: 8'h00};
    vecs[18] = '{wr: 1'b0, addr: 3'd0, data: 8'h00, exp: 8'h00};
    vecs[19] = '{wr: 1'b0, addr: 3'd7, data: 8'h00, exp: 8'hFF};

    repeat (3) @(negedge clk);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_data", {24'd0, rsp_data}, 32'd0);
    check("rst_we", {31'd0, ram_write_en}, 32'd0);
    check("rst_addr", {29'd0, ram_addr}, 32'd0);
    check("rst_wdata", {24'd0, ram_write_data}, 32'd0);
`ifdef RAM_CTRL_CLEAR_EN
    check("rst_clear_busy", {31'd0, clear_busy}, 32'd0);
`endif
    reset = 1'b0;
    @(negedge clk);

    // Write then read with exact latency.
    send(1'b1, 3'd3, 8'hA5);
    check("wr_we_high", {31'd0, ram_write_en}, 32'd1);
    check("wr_ready_low", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    check("wr_we_one_cycle", {31'd0, ram_write_en}, 32'd0);
    check("wr_back_idle", {31'd0, cmd_ready}, 32'd1);
    send(1'b0, 3'd3, 8'h00);
    check("rd_e0_valid", {31'd0, rsp_valid}, 32'd0);
    check("rd_issue_we", {31'd0, ram_write_en}, 32'd0);
    @(negedge clk);
    check("rd_e1_valid", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    check("rd_e2_valid", {31'd0, rsp_valid}, 32'd1);
    check("rd_e2_data", {24'd0, rsp_data}, 32'hA5);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rd_done_valid", {31'd0, rsp_valid}, 32'd0);

    // Table: back-to-back writes, in-order reads, boundary addresses.
    for (int i = 0; i < 20; i++) begin
      if (vecs[i].wr) send(1'b1, vecs[i].addr, vecs[i].data);
      else read_expect($sformatf("vec%0d_addr%0d", i, vecs[i].addr), vecs[i].addr, vecs[i].exp);
    end
    @(negedge clk);

    // Back-pressure: response held stable with cmd_ready low.
    read_expect("pre_stall", 3'd2, 8'h12);
    send(1'b0, 3'd2, 8'h00);
    repeat (2) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("stall%0d_valid", k), {31'd0, rsp_valid}, 32'd1);
      check($sformatf("stall%0d_data", k), {24'd0, rsp_data}, 32'h12);
      check($sformatf("stall%0d_ready", k), {31'd0, cmd_ready}, 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("stall_release", {31'd0, rsp_valid}, 32'd0);

    // Write attempted during RESP, including the handshake cycle, must not land.
    send(1'b0, 3'd4, 8'h00);
    repeat (2) @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 3'd4; cmd_data = 8'h99;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("resp_wr%0d_ready", k), {31'd0, cmd_ready}, 32'd0);
      check($sformatf("resp_wr%0d_we", k), {31'd0, ram_write_en}, 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    check("resp_hs_ready", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    cmd_valid = 1'b0; rsp_ready = 1'b0;
    check("resp_hs_we", {31'd0, ram_write_en}, 32'd0);
    check("resp_hs_valid", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    read_expect("resp_wr_unchanged", 3'd4, 8'h14);

    // Reset while in RD_CAPT drops the response; RAM comes back zeroed.
    send(1'b1, 3'd5, 8'hFF);
    read_expect("pre_reset_ff", 3'd5, 8'hFF);
    send(1'b0, 3'd5, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_valid", {31'd0, rsp_valid}, 32'd0);
    check("midrst_ready", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    check("midrst_still_no_rsp", {31'd0, rsp_valid}, 32'd0);
    read_expect("midrst_reread", 3'd5, 8'h00);

`ifdef RAM_CTRL_CLEAR_EN
    begin
      int busy_cycles;
      int n;
      for (int i = 0; i < 8; i++) send(1'b1, 3'(i), 8'h3C);
      @(negedge clk);
      read_expect("pre_clear", 3'd6, 8'h3C);
      clear = 1'b1;
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 3'd1; cmd_data = 8'h77;
      check("clear_blocks_ready", {31'd0, cmd_ready}, 32'd0);
      @(negedge clk);
      clear = 1'b0; cmd_valid = 1'b0;
      busy_cycles = 0;
      n = 0;
      while (clear_busy && n < 20) begin
        busy_cycles++;
        check($sformatf("clear%0d_we", n), {31'd0, ram_write_en}, 32'd1);
        check($sformatf("clear%0d_ready", n), {31'd0, cmd_ready}, 32'd0);
        @(negedge clk);
        n++;
      end
      check("clear_busy_cycles", busy_cycles, 32'd8);
      check("clear_done_ready", {31'd0, cmd_ready}, 32'd1);
      for (int i = 0; i < 8; i++) read_expect($sformatf("clear_rd%0d", i), 3'(i), 8'h00);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
